fetch_unit: RTL and testbench

- Initiator side of the instruction-memory read interface.
- Owns the fetch PC and drives it to the instruction memory, which returns the word combinationally in the same cycle.
- Captures {pc, instruction} pairs into a small skid FIFO and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects from execute by flushing buffered instructions and restarting fetch at the target.

---
 rtl/fetch_unit_pkg.sv | 32 +++
 rtl/fetch_fifo.sv | 47 ++++
 rtl/fetch_unit.sv | 68 ++++++
 tb/tb_fetch_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path definitions: address width, reset vector and the
// {pc, instruction} entry layout carried through the fetch FIFO.
package fetch_unit_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned INST_BYTES       = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;

  localparam int unsigned ENTRY_W      = 64;
  localparam int unsigned ENTRY_PC_MSB = 63;
  localparam int unsigned ENTRY_PC_LSB = 32;
  localparam int unsigned ENTRY_IN_MSB = 31;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [XLEN-1:0] pc,
                                                    input logic [XLEN-1:0] word);
    return {pc, word};
  endfunction

  function automatic logic [XLEN-1:0] entry_pc(input logic [ENTRY_W-1:0] e);
    return e[ENTRY_PC_MSB:ENTRY_PC_LSB];
  endfunction

  function automatic logic [XLEN-1:0] entry_inst(input logic [ENTRY_W-1:0] e);
    return e[ENTRY_IN_MSB:0];
  endfunction

  // Redirect targets are word-aligned by dropping the two low bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; head reads as zero when empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (!reset && !flush && push) mem[wr_ptr] <= din;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, buffers {pc, inst} pairs for decode
// and restarts at execute's redirect target.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_pc,
  output logic        imem_read_write,
  output logic [31:0] imem_data_in,
  input  logic [31:0] imem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  logic [XLEN-1:0]    fpc;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;
  logic               full;
  logic               pop;
  logic               push;

  assign full       = (count == CNT_W'(BUF_DEPTH));
  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready;
  // A full buffer still accepts a fetch when the head leaves the same cycle.
  assign push       = !redirect_valid & (!full | pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      fpc <= RESET_PC;
    end else if (redirect_valid) begin
      fpc <= align_pc(redirect_pc);
    end else if (push) begin
      fpc <= fpc + XLEN'(INST_BYTES);
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (make_entry(fpc, imem_data_out)),
    .count (count),
    .head  (head)
  );

  assign imem_pc         = fpc;
  assign imem_read_write = 1'b0;
  assign imem_data_in    = '0;
  assign inst            = entry_inst(head);
  assign inst_pc         = entry_pc(head);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table plus randomized traffic
// checked against a queue-based model of the fetch buffer.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_pc;
  logic        imem_read_write;
  logic [31:0] imem_data_in;
  logic [31:0] imem_data_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int tests = 0;
  int fails = 0;

  logic [63:0] mq[$];
  logic [31:0] m_fpc;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eimem;
  } vec_t;

  vec_t tbl[$];

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0100_0000: return 32'h0050_0093;
      32'h0100_0004: return 32'h0010_0113;
      32'h0100_0008: return 32'h0020_81B3;
      default:       return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign imem_data_out = mem_word(imem_pc);

  fetch_unit #(
    .RESET_PC  (RPC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_pc         (imem_pc),
    .imem_read_write (imem_read_write),
    .imem_data_in    (imem_data_in),
    .imem_data_out   (imem_data_out),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    logic [63:0] e;
    reset          = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    inst_ready     = rdy;
    @(posedge clock);
    if (r) begin
      mq.delete();
      m_fpc = RPC;
    end else if (rv) begin
      mq.delete();
      m_fpc = rp & 32'hFFFF_FFFC;
    end else begin
      if (rdy && mq.size() != 0) void'(mq.pop_front());
      if (mq.size() < DEPTH) begin
        mq.push_back({m_fpc, mem_word(m_fpc)});
        m_fpc = m_fpc + 32'd4;
      end
    end
    #1;
    e = (mq.size() != 0) ? mq[0] : 64'd0;
    chk("model_valid", {31'd0, inst_valid}, {31'd0, mq.size() != 0});
    chk("model_inst_pc", inst_pc, e[63:32]);
    chk("model_inst", inst, e[31:0]);
    chk("model_imem_pc", imem_pc, m_fpc);
  endtask

  function automatic void addv(input logic rst, input logic rv, input logic [31:0] rpc,
                               input logic rdy, input logic ev, input logic [31:0] epc,
                               input logic [31:0] eimem);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.eimem = eimem;
    tbl.push_back(v);
  endfunction

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    m_fpc          = RPC;

    // Back-to-back delivery after reset
    addv(1, 0, 0, 1, 0, 32'h0,         32'h0100_0000);
    addv(0, 0, 0, 1, 1, 32'h0100_0000, 32'h0100_0004);
    addv(0, 0, 0, 1, 1, 32'h0100_0004, 32'h0100_0008);
    addv(0, 0, 0, 1, 1, 32'h0100_0008, 32'h0100_000C);
    // Stall until full, then drain in order
    addv(1, 0, 0, 0, 0, 32'h0,         32'h0100_0000);
    addv(0, 0, 0, 0, 1, 32'h0100_0000, 32'h0100_0004);
    addv(0, 0, 0, 0, 1, 32'h0100_0000, 32'h0100_0008);
    addv(0, 0, 0, 0, 1, 32'h0100_0000, 32'h0100_0008);
    addv(0, 0, 0, 0, 1, 32'h0100_0000, 32'h0100_0008);
    addv(0, 0, 0, 0, 1, 32'h0100_0000, 32'h0100_0008);
    addv(0, 0, 0, 1, 1, 32'h0100_0004, 32'h0100_000C);
    addv(0, 0, 0, 1, 1, 32'h0100_0008, 32'h0100_0010);
    // Redirect while full, then misaligned redirect
    addv(0, 1, 32'h0100_0040, 1, 0, 32'h0,         32'h0100_0040);
    addv(0, 0, 0,             1, 1, 32'h0100_0040, 32'h0100_0044);
    addv(0, 1, 32'h0100_0043, 1, 0, 32'h0,         32'h0100_0040);
    addv(0, 0, 0,             1, 1, 32'h0100_0040, 32'h0100_0044);
    // Address wrap
    addv(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,         32'hFFFF_FFFC);
    addv(0, 0, 0,             1, 1, 32'hFFFF_FFFC, 32'h0000_0000);
    addv(0, 0, 0,             1, 1, 32'h0000_0000, 32'h0000_0004);
    addv(0, 0, 0,             1, 1, 32'h0000_0004, 32'h0000_0008);
    // Fill, then reset with a coincident redirect
    addv(0, 0, 0,             0, 1, 32'h0000_0004, 32'h0000_000C);
    addv(1, 1, 32'h0100_0080, 1, 0, 32'h0,         32'h0100_0000);
    addv(0, 0, 0,             1, 1, 32'h0100_0000, 32'h0100_0004);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("v%0d_inst_pc", i), inst_pc, tbl[i].epc);
      chk($sformatf("v%0d_inst", i), inst, tbl[i].ev ? mem_word(tbl[i].epc) : 32'h0);
      chk($sformatf("v%0d_imem_pc", i), imem_pc, tbl[i].eimem);
    end
    chk("imem_read_write", {31'd0, imem_read_write}, 32'd0);
    chk("imem_data_in", imem_data_in, 32'd0);

    // Back-to-back redirects: the later target wins, nothing is buffered
    step(0, 1, 32'h0000_0100, 1);
    step(0, 1, 32'h0000_0200, 0);
    chk("b2b_imem_pc", imem_pc, 32'h0000_0200);
    chk("b2b_valid", {31'd0, inst_valid}, 32'd0);
    step(0, 0, 0, 0);
    chk("b2b_inst_pc", inst_pc, 32'h0000_0200);
    chk("b2b_inst", inst, mem_word(32'h0000_0200));

    for (int n = 0; n < 3000; n++) begin
      logic        r;
      logic        rv;
      logic [31:0] rp;
      r  = ($urandom_range(0, 99) == 0);
      rv = ($urandom_range(0, 19) == 0);
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : 32'($urandom);
      step(r, rv, rp, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
